mvm_accum: RTL and testbench
============================

# mvm_accum

Result-side accumulator for the MVM datapath. Consumes one signed partial product per valid beat, framed by the `accum_first`/`accum_last` strobes from the MVM controller, and sums each output element across its vector chunks. Completed sums are pushed into a small output FIFO with a valid/ready interface toward the result writer. The input side has no backpressure; protocol violations and drops are reported through sticky flags.

## Interface
- IWIDTH, 32: width of signed partial-product input.
- OWIDTH, 32: width of signed accumulator and result; must be >= IWIDTH.
- FIFO_DEPTH, 4: output FIFO entries; power of 2, >= 2.
- ROWW, 10: width of the result row tag.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous flush: FIFO empty, flags cleared, row tag 0, state IDLE.
- ivalid  in  1  input beat valid.
- idata  in  IWIDTH  signed partial product, sign-extended to OWIDTH.
- accum_first  in  1  beat is first chunk of a row; qualified by ivalid.
- accum_last  in  1  beat is last chunk of a row; qualified by ivalid.
- ovalid  out  1  FIFO non-empty.
- odata  out  OWIDTH  FIFO head sum.
- orow  out  ROWW  row tag of FIFO head.
- oready  in  1  consumer accepts head when ovalid & oready.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  state == ACCUM.
- ovf_err  out  1  sticky: signed overflow in any accumulate add.
- seq_err  out  1  sticky: framing violation.
- drop_err  out  1  sticky: completed sum discarded because FIFO full.

## Operation
- States: IDLE (no open row), ACCUM (row open, partial sum in acc).
- Beat = ivalid high on a clk edge. No beat: no state change.
- IDLE, beat with first: acc_next = sext(idata). With last also: push acc_next, stay IDLE; else go ACCUM.
- IDLE, beat without first: beat ignored, seq_err set, stay IDLE.
- ACCUM, beat without first: acc_next = acc + sext(idata) mod 2^OWIDTH; ovf_err set if operands same sign and result sign differs. With last: push acc_next, go IDLE.
- ACCUM, beat with first: open row abandoned (no push), seq_err set, treated as IDLE-with-first beat.
- Push: {acc_next, row_tag} written to FIFO tail; row_tag increments mod 2^ROWW on every push attempt, including dropped ones, so tags stay aligned to matrix rows.
- Full: push when count == FIFO_DEPTH and no pop that cycle -> sum dropped, drop_err set. Push and pop in same cycle while full -> both performed, count unchanged.
- Pop: ovalid & oready advances head. oready while empty: no effect.
- odata/orow stable while ovalid & !oready.
- clear has priority over beats and pops in its cycle; rst has priority over everything.

## Timing
- Reset values: ovalid 0, odata 0, orow 0, count 0, busy 0, all err flags 0, acc 0, row_tag 0, state IDLE.
- Input to output latency: beat with accum_last at edge N -> ovalid high, odata valid after edge N (one cycle) when FIFO was empty.
- Input accepted every cycle; sustained throughput one row per cycle when each row is one chunk and oready held high.
- count, ovalid, busy, flags all registered; no combinational path from ivalid/idata/oready to any output.
- Flags set on the edge of the offending beat; visible the following cycle; cleared only by rst or clear.
- rst mid-row: open partial sum discarded, FIFO contents lost.

## Test plan
- Row of 3 chunks {5, -2, 10} (first on beat 1, last on beat 3), oready=1 -> one output odata=13, orow=0, ovalid high one cycle after beat 3; busy high after beats 1-2.
- Single-chunk rows idata=1,2,3,4,5 with first&last each beat, oready=0, FIFO_DEPTH=4 -> count saturates at 4, drop_err=1, heads pop as 1,2,3,4 with orow 0..3; next row tag is 5.
- Overflow: IWIDTH=OWIDTH=32, chunks 0x7FFFFFFF then 1 -> odata=0x80000000, ovf_err=1.
- Framing: beat without first in IDLE -> ignored, seq_err=1; row {7, first again with 4, last 6} -> single output 10.
- FIFO full with oready=1 and simultaneous push -> no drop, count stays 4, order preserved.
- Mid-row rst then clear after flags set -> all outputs at reset values; next well-formed row emits orow=0.

Source files
------------

// File: rtl/mvm_accum_if.sv
// Bundles the MVM accumulator's control, input-beat and result-stream signals.
// master drives beats and oready; slave is the accumulator itself.
interface mvm_accum_if #(
  parameter int IWIDTH     = 32,
  parameter int OWIDTH     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ROWW       = 10
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              clear;
  logic              ivalid;
  logic [IWIDTH-1:0] idata;
  logic              accum_first;
  logic              accum_last;
  logic              ovalid;
  logic [OWIDTH-1:0] odata;
  logic [ROWW-1:0]   orow;
  logic              oready;
  logic [CW-1:0]     count;
  logic              busy;
  logic              ovf_err;
  logic              seq_err;
  logic              drop_err;

  modport master (
    output clear, ivalid, idata, accum_first, accum_last, oready,
    input  ovalid, odata, orow, count, busy, ovf_err, seq_err, drop_err
  );

  modport slave (
    input  clear, ivalid, idata, accum_first, accum_last, oready,
    output ovalid, odata, orow, count, busy, ovf_err, seq_err, drop_err
  );
endinterface

// File: rtl/mvm_accum.sv
// Sums framed signed partial products per output row and queues each finished
// sum with its row tag in a small FIFO; framing, overflow and drops raise sticky flags.
module mvm_accum #(
  parameter int IWIDTH     = 32,
  parameter int OWIDTH     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ROWW       = 10
) (
  input  logic       clk,
  input  logic       rst,
  mvm_accum_if.slave acc_if
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = OWIDTH + ROWW;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic signed [OWIDTH-1:0] acc_q, acc_d;
  logic signed [OWIDTH-1:0] sext_in, sum;
  logic [ROWW-1:0]          row_q;
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            count_q, count_d;
  logic                     ovf_q, seq_q, drop_q;
  logic                     push, ovf_set, seq_set;
  logic                     pop, full, wr_en, drop;
  logic [EW-1:0]            mem_q [FIFO_DEPTH];
  logic [EW-1:0]            head;

  assign sext_in = OWIDTH'($signed(acc_if.idata));
  assign sum     = acc_q + sext_in;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    seq_set = 1'b0;
    if (acc_if.ivalid) begin
      if (acc_if.accum_first) begin
        // A first beat always (re)opens a row; an abandoned open row is an error.
        seq_set = (state_q == ACCUM);
        acc_d   = sext_in;
        if (acc_if.accum_last) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ACCUM;
        end
      end else if (state_q == IDLE) begin
        seq_set = 1'b1;
      end else begin
        acc_d   = sum;
        ovf_set = (acc_q[OWIDTH-1] == sext_in[OWIDTH-1]) &&
                  (sum[OWIDTH-1] != acc_q[OWIDTH-1]);
        if (acc_if.accum_last) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end

  // A pop frees the slot in the same cycle, so push-while-full-and-popping is not a drop.
  assign pop     = (count_q != '0) && acc_if.oready;
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign wr_en   = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign count_d = count_q + CW'(wr_en) - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      row_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      seq_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else if (acc_if.clear) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      row_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      seq_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      if (push) row_q <= row_q + ROWW'(1);
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      ovf_q  <= ovf_q | ovf_set;
      seq_q  <= seq_q | seq_set;
      drop_q <= drop_q | drop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (!acc_if.clear && wr_en) begin
      mem_q[wr_ptr_q] <= {acc_d, row_q};
    end
  end

  // Head is masked while empty so stale entries never appear on the bus.
  assign head            = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign acc_if.ovalid   = (count_q != '0);
  assign acc_if.odata    = head[EW-1:ROWW];
  assign acc_if.orow     = head[ROWW-1:0];
  assign acc_if.count    = count_q;
  assign acc_if.busy     = (state_q == ACCUM);
  assign acc_if.ovf_err  = ovf_q;
  assign acc_if.seq_err  = seq_q;
  assign acc_if.drop_err = drop_q;
endmodule

// File: tb/tb_mvm_accum.sv
// Bench for mvm_accum: hand-written vector table, corner-case sequences, then
// random beats checked against a queue-based reference model.
module tb_mvm_accum;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mvm_accum_if #(.IWIDTH(32), .OWIDTH(32), .FIFO_DEPTH(DEPTH), .ROWW(10)) bus ();

  mvm_accum #(.IWIDTH(32), .OWIDTH(32), .FIFO_DEPTH(DEPTH), .ROWW(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .acc_if (bus)
  );

  typedef struct {
    logic [31:0] sum;
    logic [9:0]  row;
  } ent_t;

  typedef struct {
    logic        c, iv, f, l;
    logic [31:0] d;
    logic        rdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [9:0]  e_or;
    int          e_cnt;
    logic        e_busy, e_seq, e_drop;
  } vec_t;

  ent_t        mq[$];
  bit          m_open, m_ovf, m_seq, m_drop;
  longint      m_acc;
  logic [9:0]  m_row;
  int          n_vec = 0;
  int          n_bad = 0;
  vec_t        tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_open = 0; m_ovf = 0; m_seq = 0; m_drop = 0;
    m_acc = 0; m_row = '0;
  endtask

  // Behavioural rules: a row is opened by first, chunks are summed as integers,
  // a sum outside the 32-bit signed range flags overflow and wraps.
  task automatic model_step(input logic c, iv, f, l, input logic [31:0] d, input logic rdy);
    longint      x, s;
    logic [31:0] t;
    bit          do_push;
    ent_t        e;
    if (c) begin
      model_reset();
      return;
    end
    do_push = 0;
    x = longint'($signed(d));
    if (iv) begin
      if (f) begin
        if (m_open) m_seq = 1;
        m_acc = x;
        if (l) begin do_push = 1; m_open = 0; end
        else m_open = 1;
      end else if (!m_open) begin
        m_seq = 1;
      end else begin
        s = m_acc + x;
        if (s > 64'sd2147483647 || s < -64'sd2147483648) m_ovf = 1;
        t = s[31:0];
        m_acc = longint'($signed(t));
        if (l) begin do_push = 1; m_open = 0; end
      end
    end
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < DEPTH) begin
        t = m_acc[31:0];
        e.sum = t;
        e.row = m_row;
        mq.push_back(e);
      end else begin
        m_drop = 1;
      end
      m_row = m_row + 10'd1;
    end
  endtask

  task automatic model_check();
    chk("ovalid", 64'(bus.ovalid), 64'(mq.size() != 0));
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("busy", 64'(bus.busy), 64'(m_open));
    chk("ovf_err", 64'(bus.ovf_err), 64'(m_ovf));
    chk("seq_err", 64'(bus.seq_err), 64'(m_seq));
    chk("drop_err", 64'(bus.drop_err), 64'(m_drop));
    if (mq.size() != 0) begin
      chk("odata", 64'(bus.odata), 64'(mq[0].sum));
      chk("orow", 64'(bus.orow), 64'(mq[0].row));
    end
  endtask

  task automatic cycle(input logic c, iv, f, l, input logic [31:0] d, input logic rdy);
    bus.clear       = c;
    bus.ivalid      = iv;
    bus.accum_first = f;
    bus.accum_last  = l;
    bus.idata       = d;
    bus.oready      = rdy;
    @(posedge clk);
    #1;
    model_step(c, iv, f, l, d, rdy);
    model_check();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ovalid"}, 64'(bus.ovalid), 64'd0);
    chk({tag, "_odata"}, 64'(bus.odata), 64'd0);
    chk({tag, "_orow"}, 64'(bus.orow), 64'd0);
    chk({tag, "_count"}, 64'(bus.count), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_ovf"}, 64'(bus.ovf_err), 64'd0);
    chk({tag, "_seq"}, 64'(bus.seq_err), 64'd0);
    chk({tag, "_drop"}, 64'(bus.drop_err), 64'd0);
  endtask

  initial begin
    //           c  iv f  l  d              rdy ov odata  orow cnt busy seq drop
    tbl[0]  = '{0, 1, 1, 0, 32'd5,          1,  0, 32'd0,  0,   0,  1,   0,  0};
    tbl[1]  = '{0, 1, 0, 0, 32'hFFFFFFFE,   1,  0, 32'd0,  0,   0,  1,   0,  0};
    tbl[2]  = '{0, 1, 0, 1, 32'd10,         1,  1, 32'd13, 0,   1,  0,   0,  0};
    tbl[3]  = '{0, 0, 0, 0, 32'd0,          1,  0, 32'd0,  0,   0,  0,   0,  0};
    tbl[4]  = '{1, 0, 0, 0, 32'd0,          0,  0, 32'd0,  0,   0,  0,   0,  0};
    tbl[5]  = '{0, 1, 1, 1, 32'd1,          0,  1, 32'd1,  0,   1,  0,   0,  0};
    tbl[6]  = '{0, 1, 1, 1, 32'd2,          0,  1, 32'd1,  0,   2,  0,   0,  0};
    tbl[7]  = '{0, 1, 1, 1, 32'd3,          0,  1, 32'd1,  0,   3,  0,   0,  0};
    tbl[8]  = '{0, 1, 1, 1, 32'd4,          0,  1, 32'd1,  0,   4,  0,   0,  0};
    tbl[9]  = '{0, 1, 1, 1, 32'd5,          0,  1, 32'd1,  0,   4,  0,   0,  1};
    tbl[10] = '{0, 0, 0, 0, 32'd0,          1,  1, 32'd2,  1,   3,  0,   0,  1};
    tbl[11] = '{0, 0, 0, 0, 32'd0,          1,  1, 32'd3,  2,   2,  0,   0,  1};
    tbl[12] = '{0, 0, 0, 0, 32'd0,          1,  1, 32'd4,  3,   1,  0,   0,  1};
    tbl[13] = '{0, 0, 0, 0, 32'd0,          1,  0, 32'd0,  0,   0,  0,   0,  1};
    tbl[14] = '{0, 1, 1, 1, 32'd9,          0,  1, 32'd9,  5,   1,  0,   0,  1};

    rst = 1'b1;
    bus.clear = 0; bus.ivalid = 0; bus.accum_first = 0; bus.accum_last = 0;
    bus.idata = '0; bus.oready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].c, tbl[i].iv, tbl[i].f, tbl[i].l, tbl[i].d, tbl[i].rdy);
      chk("tbl_ovalid", 64'(bus.ovalid), 64'(tbl[i].e_ov));
      chk("tbl_count", 64'(bus.count), 64'(tbl[i].e_cnt));
      chk("tbl_busy", 64'(bus.busy), 64'(tbl[i].e_busy));
      chk("tbl_seq", 64'(bus.seq_err), 64'(tbl[i].e_seq));
      chk("tbl_drop", 64'(bus.drop_err), 64'(tbl[i].e_drop));
      if (tbl[i].e_ov) begin
        chk("tbl_odata", 64'(bus.odata), 64'(tbl[i].e_od));
        chk("tbl_orow", 64'(bus.orow), 64'(tbl[i].e_or));
      end
    end

    // Signed overflow wraps and sets the sticky flag
    cycle(1, 0, 0, 0, 32'd0, 0);
    cycle(0, 1, 1, 0, 32'h7FFFFFFF, 0);
    cycle(0, 1, 0, 1, 32'd1, 0);
    chk("ovf_odata", 64'(bus.odata), 64'h80000000);
    chk("ovf_flag", 64'(bus.ovf_err), 64'd1);

    // Framing: stray beat ignored, re-opened row abandoned
    cycle(1, 0, 0, 0, 32'd0, 0);
    chk("clear_ovf", 64'(bus.ovf_err), 64'd0);
    cycle(0, 1, 0, 0, 32'd3, 0);
    chk("frm_seq", 64'(bus.seq_err), 64'd1);
    chk("frm_cnt0", 64'(bus.count), 64'd0);
    cycle(0, 1, 1, 0, 32'd7, 0);
    cycle(0, 1, 1, 0, 32'd4, 0);
    cycle(0, 1, 0, 1, 32'd6, 0);
    chk("frm_odata", 64'(bus.odata), 64'd10);
    chk("frm_cnt1", 64'(bus.count), 64'd1);

    // Full FIFO with simultaneous push and pop
    cycle(1, 0, 0, 0, 32'd0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 1, 1, 1, 32'(11 + k), 0);
    cycle(0, 1, 1, 1, 32'd15, 1);
    chk("fp_count", 64'(bus.count), 64'd4);
    chk("fp_drop", 64'(bus.drop_err), 64'd0);
    for (int k = 0; k < 4; k++) begin
      chk("fp_order", 64'(bus.odata), 64'(12 + k));
      cycle(0, 0, 0, 0, 32'd0, 1);
    end
    chk("fp_empty", 64'(bus.ovalid), 64'd0);

    // Asynchronous reset mid-row, then clear and a fresh row
    cycle(0, 1, 1, 1, 32'd3, 0);
    cycle(0, 1, 1, 0, 32'd5, 0);
    cycle(0, 1, 1, 0, 32'd6, 0);
    chk("mid_busy", 64'(bus.busy), 64'd1);
    #3 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cycle(1, 0, 0, 0, 32'd0, 0);
    check_reset_outputs("post_clear");
    cycle(0, 1, 1, 1, 32'd8, 0);
    chk("fresh_orow", 64'(bus.orow), 64'd0);
    chk("fresh_odata", 64'(bus.odata), 64'd8);

    // Random beats against the reference model
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] d;
      int          v;
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
      end else begin
        v = int'($urandom_range(0, 40)) - 20;
        d = v;
      end
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4), d,
            ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
